scanout_controller: RTL
=======================

SCANOUT_CONTROLLER -- requirements
Module: scanout_controller

Interface
REQ-001 SHALL have parameter H_OFFSET, default 64: first visible column of the doubled image window (0..128).
REQ-002 SHALL have parameter BORDER_COLOR, default 8'h25: pixel value for visible area outside the window when SCANOUT_BORDER_EN is defined.
REQ-003 SHALL have port clk, input, 1: single system clock (50 MHz); the framebuffer read port clock is tied to clk.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1: scanout enable; low parks the timing at (0,0).
REQ-006 SHALL have port rd_addr, output, 16: framebuffer read address {y_img[7:0], x_img[7:0]}.
REQ-007 SHALL have port rd_data, input, 8: framebuffer read data, valid one clk after rd_addr changes.
REQ-008 SHALL have port pixel, output, 8: RGB332 pixel to the DAC.
REQ-009 SHALL have ports hsync_n and vsync_n, outputs, 1 each: active-low syncs.
REQ-010 SHALL have port de, output, 1: data enable, high in the visible 640x480 area.
REQ-011 SHALL have port vblank, output, 1: high while v_cnt >= 480, for tear-free upstream writes.
REQ-012 SHALL have port frame_start, output, 1: one-clk pulse when the counters wrap to (0,0).

Function
REQ-013 SHALL generate pix_ce toggling every clk (25 MHz pixel rate); h_cnt and v_cnt advance only on clk edges where pix_ce=1.
REQ-014 SHALL count h_cnt 0..799, wrapping to 0; at the wrap v_cnt increments 0..524 and then wraps to 0.
REQ-015 SHALL assert horizontal sync for h_cnt 656..751 and vertical sync for v_cnt 490..491; visible area is h<640 and v<480.
REQ-016 SHALL treat the image window as h in [H_OFFSET, H_OFFSET+512) and v<480, with x_img=(h-H_OFFSET)>>1 and y_img=v>>1 (0..239).
REQ-017 SHALL register rd_addr on the same edge as the counter update, using the new counter position; rd_addr=16'h0000 outside the window.
REQ-018 SHALL register pixel, hsync_n, vsync_n, and de on the next pix_ce edge, 2 clk after rd_addr, so every output lags the counters by exactly one pixel period.
REQ-019 SHALL set pixel=rd_data inside the window and pixel=8'h00 whenever de would be low.
REQ-020 SHALL pulse frame_start for the single clk in which (h,v) becomes (0,0); vblank SHALL be combinational from v_cnt.
REQ-021 SHALL, when en is sampled low, force h_cnt=v_cnt=0, pix_ce=0, rd_addr=0, pixel=0, de=0, hsync_n=vsync_n=1, and frame_start=0 on the next clk.
REQ-022 SHALL, when en rises, start at (0,0) with its first pix_ce edge 1 clk later, and SHALL NOT emit frame_start for that restart.

Reset
REQ-023 SHALL, while rst_n=0, immediately force counters=0, pix_ce=0, rd_addr=0, pixel=0, de=0, hsync_n=1, vsync_n=1, and frame_start=0.
REQ-024 SHALL, on deassertion of rst_n mid-frame, restart exactly as in REQ-022, with no partial sync pulse.

Configuration
REQ-025 SHALL honour the macro SCANOUT_BORDER_EN: when defined, visible pixels outside the window output BORDER_COLOR; when undefined, they output 8'h00, and BORDER_COLOR is unused.

Verification
REQ-026 Reset, then en=1 for one full frame -> 800*525*2=840000 clk between frame_start pulses; hsync_n low for 192 clk per line; vsync_n low for 2 lines.
REQ-027 Memory model returning rd_data=rd_addr[7:0]^rd_addr[15:8] -> at output position h=64,v=0 pixel=8'h00; at h=66,v=2 pixel=8'h00; at h=67,v=3 pixel=8'h00, with x_img=1, y_img=1, and the address lag checked to be 2 clk.
REQ-028 Output position h=575 versus h=576 on line 10 -> pixel=rd_data for address {8'd5,8'd255}, then border (8'h25 with SCANOUT_BORDER_EN, 8'h00 without).
REQ-029 Drop en at h=300,v=200 -> next clk: de=0, syncs high, rd_addr=0; raise en -> no frame_start until the first natural wrap, 840000 clk later.
REQ-030 Assert rst_n=0 asynchronously between clk edges during vsync -> vsync_n=1 and de=0 without waiting for a clk edge.

Source files
------------

// File: rtl/scanout_controller.sv
// scanout_controller
//   Generates 640x480@60 VGA timing from a 50 MHz clock (25 MHz pixel rate
//   via an internal clock-enable) and scans a 256x240 framebuffer out as a
//   2x-doubled 512x480 window placed at column H_OFFSET.
//
// Parameters
//   H_OFFSET     first visible column of the doubled window (0..128)
//   BORDER_COLOR pixel value for visible area outside the window
//
// Build option
//   SCANOUT_BORDER_EN  when defined, visible pixels outside the window show
//                      BORDER_COLOR; otherwise they show 8'h00.
//
// Ports
//   clk          system clock, 50 MHz (framebuffer read port shares it)
//   rst_n        asynchronous active-low reset
//   en           scanout enable; low parks the timing at (0,0)
//   rd_addr      framebuffer read address {y_img, x_img}
//   rd_data      framebuffer read data, valid one clk after rd_addr
//   pixel        RGB332 pixel to the DAC
//   hsync_n      active-low horizontal sync
//   vsync_n      active-low vertical sync
//   de           data enable, high in the visible 640x480 area
//   vblank       high while the vertical counter is at or beyond line 480
//   frame_start  one-clk pulse when the counters wrap to (0,0)
module scanout_controller #(
  parameter int unsigned H_OFFSET     = 64,
  parameter logic [7:0]  BORDER_COLOR = 8'h25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  pixel,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic        vblank,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] H_VIS     = 10'd640;
  localparam logic [9:0] HS_FIRST  = 10'd656;
  localparam logic [9:0] HS_LAST   = 10'd751;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] V_VIS     = 10'd480;
  localparam logic [9:0] VS_FIRST  = 10'd490;
  localparam logic [9:0] VS_LAST   = 10'd491;
  localparam logic [9:0] WIN_FIRST = 10'(H_OFFSET);
  localparam logic [9:0] WIN_END   = WIN_FIRST + 10'd512;

`ifdef SCANOUT_BORDER_EN
  localparam logic [7:0] OUTSIDE_COLOR = BORDER_COLOR;
`else
  // Border disabled: the parameter is masked out so it has no effect.
  localparam logic [7:0] OUTSIDE_COLOR = BORDER_COLOR & 8'h00;
`endif

  logic        pixCe_r;
  logic [9:0]  hCnt_r;
  logic [9:0]  vCnt_r;
  logic [15:0] rdAddr_r;
  logic [7:0]  pixel_r;
  logic        de_r;
  logic        hsyncN_r;
  logic        vsyncN_r;
  logic        frameStart_r;

  logic [9:0]  hNext_s;
  logic [9:0]  vNext_s;
  logic        nextInWin_s;
  logic [7:0]  xImg_s;
  logic [7:0]  yImg_s;
  logic [15:0] nextAddr_s;
  logic        curVis_s;
  logic        curInWin_s;
  logic        curHs_s;
  logic        curVs_s;
  logic        wrap_s;
  logic [7:0]  curPix_s;

  // Counter position for the coming pixel period
  always_comb begin
    hNext_s = hCnt_r;
    vNext_s = vCnt_r;
    if (hCnt_r == H_LAST) begin
      hNext_s = 10'd0;
      if (vCnt_r == V_LAST) begin
        vNext_s = 10'd0;
      end else begin
        vNext_s = vCnt_r + 10'd1;
      end
    end else begin
      hNext_s = hCnt_r + 10'd1;
    end
  end

  // Framebuffer address for the coming position (fetched one pixel ahead)
  always_comb begin
    nextInWin_s = (hNext_s >= WIN_FIRST) && (hNext_s < WIN_END) && (vNext_s < V_VIS);
    xImg_s      = 8'((hNext_s - WIN_FIRST) >> 10'd1);
    yImg_s      = 8'(vNext_s >> 10'd1);
    if (nextInWin_s) begin
      nextAddr_s = {yImg_s, xImg_s};
    end else begin
      nextAddr_s = 16'h0000;
    end
  end

  // Attributes of the position currently held by the counters; these become
  // the outputs at the next pixel edge, when its fetched data has arrived.
  always_comb begin
    curVis_s   = (hCnt_r < H_VIS) && (vCnt_r < V_VIS);
    curInWin_s = (hCnt_r >= WIN_FIRST) && (hCnt_r < WIN_END) && (vCnt_r < V_VIS);
    curHs_s    = (hCnt_r >= HS_FIRST) && (hCnt_r <= HS_LAST);
    curVs_s    = (vCnt_r >= VS_FIRST) && (vCnt_r <= VS_LAST);
    wrap_s     = (hCnt_r == H_LAST) && (vCnt_r == V_LAST);
    if (curInWin_s) begin
      curPix_s = rd_data;
    end else if (curVis_s) begin
      curPix_s = OUTSIDE_COLOR;
    end else begin
      curPix_s = 8'h00;
    end
  end

  // Pixel enable, counters, read address and registered video outputs.
  // Disable and reset both park everything at (0,0) with pix_ce low, so the
  // first pixel edge after a restart lands exactly one clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixCe_r      <= 1'b0;
      hCnt_r       <= 10'd0;
      vCnt_r       <= 10'd0;
      rdAddr_r     <= 16'h0000;
      pixel_r      <= 8'h00;
      de_r         <= 1'b0;
      hsyncN_r     <= 1'b1;
      vsyncN_r     <= 1'b1;
      frameStart_r <= 1'b0;
    end else if (!en) begin
      pixCe_r      <= 1'b0;
      hCnt_r       <= 10'd0;
      vCnt_r       <= 10'd0;
      rdAddr_r     <= 16'h0000;
      pixel_r      <= 8'h00;
      de_r         <= 1'b0;
      hsyncN_r     <= 1'b1;
      vsyncN_r     <= 1'b1;
      frameStart_r <= 1'b0;
    end else begin
      pixCe_r      <= ~pixCe_r;
      frameStart_r <= 1'b0;
      if (pixCe_r) begin
        hCnt_r       <= hNext_s;
        vCnt_r       <= vNext_s;
        rdAddr_r     <= nextAddr_s;
        frameStart_r <= wrap_s;
        pixel_r      <= curPix_s;
        de_r         <= curVis_s;
        hsyncN_r     <= ~curHs_s;
        vsyncN_r     <= ~curVs_s;
      end else begin
        hCnt_r       <= hCnt_r;
        vCnt_r       <= vCnt_r;
        rdAddr_r     <= rdAddr_r;
        pixel_r      <= pixel_r;
        de_r         <= de_r;
        hsyncN_r     <= hsyncN_r;
        vsyncN_r     <= vsyncN_r;
      end
    end
  end

  assign rd_addr     = rdAddr_r;
  assign pixel       = pixel_r;
  assign de          = de_r;
  assign hsync_n     = hsyncN_r;
  assign vsync_n     = vsyncN_r;
  assign frame_start = frameStart_r;
  assign vblank      = (vCnt_r >= V_VIS);

endmodule
